// File: rtl/fpu_pkg.sv
// Shared opcode and FSM state definitions for the FPU arbiter.
// Imported by the arbiter top and its round-robin search.
package fpu_pkg;

    localparam int OP_W   = 2;
    localparam int DATA_W = 32;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fpu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request after
// last_grant, wrapping modulo N, returned as a one-hot grant.
module rr_arbiter
    import fpu_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_grant,
    output logic [N-1:0]   grant
);

    logic [IDW:0] pos;
    logic         found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 1; k <= N; k++) begin
            pos = {1'b0, last_grant} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(N)) begin
                pos = pos - (IDW+1)'(N);
            end
            if (!found && req[pos[IDW-1:0]]) begin
                grant[pos[IDW-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one fixed-latency FPU among NREQ requesters with
// round-robin arbitration and a one-cycle response strobe.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int FPU_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [2*NREQ-1:0]        req_op,
    input  logic [32*NREQ-1:0]       req_a,
    input  logic [32*NREQ-1:0]       req_b,
    output logic [1:0]               fpu_zt,
    output logic [31:0]              fpu_a,
    output logic [31:0]              fpu_b,
    input  logic [31:0]              fpu_s,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [31:0]              rsp_data,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(FPU_LAT + 1);

    state_e          state;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  gid;
    logic [CW-1:0]   counter;
    logic [NREQ-1:0] grant;
    logic [1:0]      sel_op;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [IDW-1:0]  sel_id;
    logic            accept;

    rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Grant is one-hot, so the operand mux is a plain scan.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        sel_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_id = IDW'(i);
            end
        end
    end

    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            gid        <= '0;
            counter    <= '0;
            fpu_zt     <= '0;
            fpu_a      <= '0;
            fpu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        fpu_zt     <= sel_op;
                        fpu_a      <= sel_a;
                        fpu_b      <= sel_b;
                        gid        <= sel_id;
                        last_grant <= sel_id;
                        counter    <= CW'(FPU_LAT);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    counter <= counter - 1'b1;
                    if (counter == CW'(1)) begin
                        rsp_data  <= fpu_s;
                        rsp_id    <= gid;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one FPU (2..8).
REQ-002 SHALL have parameter FPU_LAT, default 4, FPU cycles from stable ZT/A/B to valid S (at least 1).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  NREQ  per-requester accept; at most one bit high.
REQ-007 SHALL have port req_op  input  2*NREQ  per-requester opcode, slice i at [2i+1:2i].
REQ-008 SHALL have port req_a  input  32*NREQ  per-requester operand A (IEEE-754 single).
REQ-009 SHALL have port req_b  input  32*NREQ  per-requester operand B.
REQ-010 SHALL have port fpu_zt  output  2  opcode to FPU.
REQ-011 SHALL have port fpu_a  output  32  operand A to FPU.
REQ-012 SHALL have port fpu_b  output  32  operand B to FPU.
REQ-013 SHALL have port fpu_s  input  32  FPU result.
REQ-014 SHALL have port rsp_valid  output  1  one-cycle result strobe; consumers always accept.
REQ-015 SHALL have port rsp_id  output  $clog2(NREQ)  requester index owning the result.
REQ-016 SHALL have port rsp_data  output  32  captured FPU result.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL use opcodes 00 add, 01 sub, 10 mul, 11 div, passed to fpu_zt unchanged.
REQ-019 SHALL implement states IDLE, WAIT, RESP.
REQ-020 In IDLE, SHALL assert req_ready only for the round-robin winner among valid requesters: search starts at last_grant+1 and wraps modulo NREQ.
REQ-021 Acceptance is req_valid[g] and req_ready[g] at an edge; on that edge SHALL register the winner's op/A/B into fpu_zt/fpu_a/fpu_b, record g, set last_grant=g, load counter with FPU_LAT, and enter WAIT.
REQ-022 SHALL hold fpu_zt/fpu_a/fpu_b stable from acceptance until the next acceptance.
REQ-023 In WAIT, SHALL decrement counter each edge; at the edge where counter equals 1, SHALL capture fpu_s into rsp_data, load rsp_id=g, and enter RESP.
REQ-024 In RESP, SHALL assert rsp_valid for exactly one cycle, i.e. FPU_LAT cycles after the acceptance edge, then return to IDLE.
REQ-025 SHALL keep req_ready all-zero in WAIT and RESP; throughput is at most one operation per FPU_LAT+2 cycles.
REQ-026 A requester dropping req_valid before acceptance SHALL lose nothing and cause no acceptance.
REQ-027 With a single valid requester, SHALL grant it repeatedly with no idle penalty beyond REQ-025.
REQ-028 With all NREQ requesters continuously valid, SHALL grant each exactly once per NREQ consecutive acceptances.
REQ-029 rsp_data and rsp_id SHALL hold their last values outside RESP.

Reset
REQ-030 On rst high at an edge, SHALL enter IDLE, abandon any in-flight operation without a rsp_valid, and clear req_ready, rsp_valid, busy, fpu_zt, fpu_a, fpu_b, rsp_data, rsp_id and counter to 0.
REQ-031 On reset, SHALL set last_grant to NREQ-1, so requester 0 has first priority.

Structure
REQ-032 The opcode constants and the state encoding SHALL live in shared package fpu_pkg.
REQ-033 The round-robin winner search SHALL be a combinational sub-module rr_arbiter (inputs request vector and last_grant; output one-hot grant).

Verification
REQ-034 Single op: requester 1 sends op 00, A 0x3F800000, B 0x40000000 with FPU_LAT=4 -> ready[1] in the same cycle; rsp_valid 4 cycles after acceptance; rsp_id 1; rsp_data 0x40400000.
REQ-035 Contention: all 4 valid from reset -> acceptance order 0,1,2,3,0; each request pulses rsp_valid once with the matching rsp_id.
REQ-036 Mul/div: op 10, A 0x40000000, B 0x40400000 -> 0x40C00000; then op 11, A 0x40C00000, B 0x40000000 -> 0x40400000.
REQ-037 Operand stability: during WAIT, change req_a and req_b of all requesters -> fpu_a and fpu_b unchanged; result matches the accepted operands.
REQ-038 Reset mid-WAIT: assert rst 2 cycles after acceptance -> no rsp_valid follows; next grant goes to requester 0.
REQ-039 Withdrawal: requester 2 raises then drops req_valid while the FPU is busy -> no acceptance for requester 2 and no response for it.
